// File: rtl/y_trace_checker.sv
// Trace checker: compares reference and netlist y streams, MISR-compacts both.
// Optional macro Y_TRACE_CHECKER_X_CHECK_EN flags x/z on y_dut (simulation only).
module y_trace_checker #(
  parameter int          Y_W   = 421,
  parameter int          CYC_W = 16,
  parameter int          SIG_W = 32,
  parameter logic [31:0] POLY  = 32'h04C11DB7,
  parameter logic [31:0] SEED  = 32'hFFFFFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CYC_W-1:0] num_cycles,
  input  logic [Y_W-1:0]   y_ref,
  input  logic [Y_W-1:0]   y_dut,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [CYC_W-1:0] first_bad_cyc,
  output logic [CYC_W-1:0] bad_count,
  output logic [SIG_W-1:0] sig_ref,
  output logic [SIG_W-1:0] sig_dut
);

  localparam int NSL = (Y_W + SIG_W - 1) / SIG_W;
  localparam int PW  = NSL * SIG_W;

  localparam logic [SIG_W-1:0] POLY_S = SIG_W'(POLY);
  localparam logic [SIG_W-1:0] SEED_S = SIG_W'(SEED);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [CYC_W-1:0] n;
  logic [CYC_W-1:0] idx;

  logic             neq;
  logic [SIG_W-1:0] f_ref;
  logic [SIG_W-1:0] f_dut;

  // Zero-pad to whole slices, then XOR all slices together.
  function automatic logic [SIG_W-1:0] fold(
    input logic [Y_W-1:0] y
  );
    logic [PW-1:0]    p;
    logic [SIG_W-1:0] acc;
    p   = PW'(y);
    acc = '0;
    for (int i = 0; i < NSL; i++) begin
      acc = acc ^ p[i*SIG_W +: SIG_W];
    end
    return acc;
  endfunction

  function automatic logic [SIG_W-1:0] misr(
    input logic [SIG_W-1:0] s,
    input logic [SIG_W-1:0] f
  );
    logic [SIG_W-1:0] fb;
    fb = s[SIG_W-1] ? POLY_S : '0;
    return {s[SIG_W-2:0], 1'b0} ^ fb ^ f;
  endfunction

`ifdef Y_TRACE_CHECKER_X_CHECK_EN
  logic xbad;

  always_comb begin
    xbad  = 1'b0;
    neq   = 1'b0;
    f_ref = fold(y_ref);
    f_dut = fold(y_dut);
    if ((^y_dut) === 1'bx) begin
      xbad = 1'b1;
    end
    if (xbad) begin
      neq   = 1'b1;
      f_dut = '1;
    end else if (y_ref != y_dut) begin
      neq = 1'b1;
    end
  end
`else
  always_comb begin
    neq   = 1'b0;
    f_ref = fold(y_ref);
    f_dut = fold(y_dut);
    if (y_ref != y_dut) begin
      neq = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      n             <= '0;
      idx           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      mismatch      <= 1'b0;
      first_bad_cyc <= '1;
      bad_count     <= '0;
      sig_ref       <= SEED_S;
      sig_dut       <= SEED_S;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            n             <= num_cycles;
            idx           <= '0;
            mismatch      <= 1'b0;
            first_bad_cyc <= '1;
            bad_count     <= '0;
            sig_ref       <= SEED_S;
            sig_dut       <= SEED_S;
            if (num_cycles != '0) begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          sig_ref <= misr(sig_ref, f_ref);
          sig_dut <= misr(sig_dut, f_dut);
          if (neq) begin
            mismatch  <= 1'b1;
            bad_count <= bad_count + CYC_W'(1);
            if (first_bad_cyc == '1) begin
              first_bad_cyc <= idx;
            end
          end
          // start is deliberately ignored here; n stays as latched.
          if (idx == n - CYC_W'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx <= idx + CYC_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
